// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: EXU request in, valid/ready data-memory bus out,
// aligned/extended load result and error code back to WBU.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   in_*                EXU request (valid/ready), latched on accept
//   mem_req_*           word-aligned memory request with byte mask
//   mem_rsp_*           single-cycle read data / write ack
//   out_*               result to WBU (valid/ready), err 01 align, 10 timeout
module ysyx_25060170_lsu #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_wen,
  input  logic        in_ren,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,

  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic [1:0]  out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
  } req_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             owen_q, owen_d;
  logic [1:0]       err_q, err_d;

  logic             bad;
  logic [1:0]       off;
  logic             is_b, is_h;
  logic [31:0]      sh;
  logic [31:0]      ld;
  logic [3:0]       wmask;
  logic [31:0]      wdata;

  // Illegal op combination, illegal size or a misaligned half/word.
  assign bad = (in_wen == in_ren)
             | (in_size == 2'b11)
             | ((in_size == 2'b01) & in_addr[0])
             | ((in_size == 2'b10) & (|in_addr[1:0]));

  assign off  = req_q.addr[1:0];
  assign is_b = (req_q.size == 2'b00);
  assign is_h = (req_q.size == 2'b01);

  always_comb begin
    wmask = 4'b1111;
    wdata = req_q.wdata;
    unique case (1'b1)
      is_b: begin
        wmask = 4'b0001 << off;
        wdata = {4{req_q.wdata[7:0]}};
      end
      is_h: begin
        wmask = 4'b0011 << off;
        wdata = {2{req_q.wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wdata = req_q.wdata;
      end
    endcase
    if (!req_q.wen) begin
      wmask = 4'b0000;
    end
  end

  assign sh = mem_rsp_rdata >> {off, 3'b000};

  always_comb begin
    ld = sh;
    unique case (1'b1)
      is_b: ld = {{24{~req_q.uns & sh[7]}}, sh[7:0]};
      is_h: ld = {{16{~req_q.uns & sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    owen_d  = owen_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          req_d.addr  = in_addr;
          req_d.wdata = in_wdata;
          req_d.wen   = in_wen;
          req_d.size  = in_size;
          req_d.uns   = in_unsigned;
          req_d.rd    = in_rd;
          rdata_d     = 32'h0;
          owen_d      = 1'b0;
          if (bad) begin
            err_d   = ERR_ALIGN;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response on the timeout cycle still completes normally.
        if (mem_rsp_valid) begin
          state_d = S_RESP;
          rdata_d = req_q.wen ? 32'h0 : ld;
          owen_d  = ~req_q.wen & (req_q.rd != 5'd0);
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          state_d = S_RESP;
          err_d   = ERR_TMO;
          rdata_d = 32'h0;
          owen_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      owen_q  <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      owen_q  <= owen_d;
      err_q   <= err_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {req_q.addr[31:2], 2'b00};
  assign mem_req_wen   = req_q.wen;
  assign mem_req_wdata = wdata;
  assign mem_req_wmask = wmask;
  assign out_valid     = (state_q == S_RESP);
  assign out_rdata     = rdata_q;
  assign out_rd        = req_q.rd;
  assign out_wen       = owen_q;
  assign out_err       = err_q;

endmodule
